// File: rtl/vjtag_scan_pkg.sv
// Shared types and constants for the virtual-JTAG scan master.
package vjtag_scan_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StUir,
    StCdr,
    StSdr,
    StUdr,
    StResp
  } scan_state_e;

  // Virtual IR codes understood by the CPU JTAG debug module.
  localparam logic [1:0] IrOcimem    = 2'b00;
  localparam logic [1:0] IrTracemem  = 2'b01;
  localparam logic [1:0] IrBreak     = 2'b10;
  localparam logic [1:0] IrTracectrl = 2'b11;

  localparam int unsigned DR_WIDTH_DEFAULT = 38;

endpackage

// File: rtl/vjtag_tck_gen.sv
// tck divider: toggles tck every TCK_DIV clk cycles while enabled, held low otherwise.
// rise/fall pulses flag the clk edge on which tck goes high/low.
module vjtag_tck_gen #(
  parameter int unsigned TCK_DIV = 2
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic en_i,
  output logic tck_o,
  output logic rise_pulse_o,
  output logic fall_pulse_o
);

  logic [7:0] cnt_q;
  logic       tck_q;
  logic       wrap;

  assign wrap = en_i && (cnt_q == 8'(TCK_DIV - 1));

  always_ff @(posedge clk_i) begin
    if (reset_i || !en_i) begin
      cnt_q <= '0;
      tck_q <= 1'b0;
    end else if (wrap) begin
      cnt_q <= '0;
      tck_q <= ~tck_q;
    end else begin
      cnt_q <= cnt_q + 8'd1;
    end
  end

  assign tck_o        = tck_q;
  assign rise_pulse_o = wrap && !tck_q;
  assign fall_pulse_o = wrap && tck_q;

endmodule

// File: rtl/vjtag_scan_master.sv
// Virtual-JTAG host: runs UIR/CDR/SDR/UDR for one command and returns the captured DR.
// Optional macro VJTAG_SCAN_IR_CAPTURE_EN reports ir_out sampled in UIR; IR-only commands
// return rsp_dr = 0.
module vjtag_scan_master
  import vjtag_scan_pkg::*;
#(
  parameter int unsigned IR_WIDTH = 2,
  parameter int unsigned DR_WIDTH = DR_WIDTH_DEFAULT,
  parameter int unsigned TCK_DIV  = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [IR_WIDTH-1:0] cmd_ir,
  input  logic [DR_WIDTH-1:0] cmd_dr,
  input  logic                cmd_ir_only,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DR_WIDTH-1:0] rsp_dr,
  output logic [IR_WIDTH-1:0] rsp_ir_out,
  output logic                tck,
  output logic                tdi,
  input  logic                tdo,
  output logic [IR_WIDTH-1:0] ir_in,
  input  logic [IR_WIDTH-1:0] ir_out,
  output logic                jtag_state_rti,
  output logic                virtual_state_uir,
  output logic                virtual_state_cdr,
  output logic                virtual_state_sdr,
  output logic                virtual_state_udr
);

  localparam int unsigned BitW = $clog2(DR_WIDTH + 1);

  scan_state_e         state_q;
  logic                ir_only_q;
  logic [DR_WIDTH-1:0] shift_q;
  logic [DR_WIDTH-1:0] rsp_dr_q;
  logic [BitW-1:0]     bit_q;
  logic [IR_WIDTH-1:0] ir_in_q;
  logic                cmd_ready_q, rsp_valid_q, tdi_q, rti_q;
  logic                uir_q, cdr_q, sdr_q, udr_q;
  logic                tck_en, rise, fall;

  assign tck_en = (state_q == StUir) || (state_q == StCdr) ||
                  (state_q == StSdr) || (state_q == StUdr);

  vjtag_tck_gen #(
    .TCK_DIV(TCK_DIV)
  ) u_tck_gen (
    .clk_i       (clk),
    .reset_i     (reset),
    .en_i        (tck_en),
    .tck_o       (tck),
    .rise_pulse_o(rise),
    .fall_pulse_o(fall)
  );

  // State changes happen on tck falling edges so every strobe rises with tck low.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      ir_only_q   <= 1'b0;
      shift_q     <= '0;
      rsp_dr_q    <= '0;
      bit_q       <= '0;
      ir_in_q     <= '0;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      tdi_q       <= 1'b0;
      rti_q       <= 1'b1;
      uir_q       <= 1'b0;
      cdr_q       <= 1'b0;
      sdr_q       <= 1'b0;
      udr_q       <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (cmd_valid && cmd_ready_q) begin
            state_q     <= StUir;
            cmd_ready_q <= 1'b0;
            rti_q       <= 1'b0;
            uir_q       <= 1'b1;
            ir_in_q     <= cmd_ir;
            shift_q     <= cmd_dr;
            ir_only_q   <= cmd_ir_only;
          end
        end
        StUir: begin
          if (fall) begin
            uir_q <= 1'b0;
            if (ir_only_q) begin
              state_q  <= StResp;
              rti_q    <= 1'b1;
              rsp_dr_q <= '0;
            end else begin
              state_q <= StCdr;
              cdr_q   <= 1'b1;
            end
          end
        end
        StCdr: begin
          if (fall) begin
            state_q <= StSdr;
            cdr_q   <= 1'b0;
            sdr_q   <= 1'b1;
            tdi_q   <= shift_q[0];
            bit_q   <= '0;
          end
        end
        StSdr: begin
          if (rise) begin
            shift_q <= {tdo, shift_q[DR_WIDTH-1:1]};
            bit_q   <= bit_q + BitW'(1);
          end else if (fall) begin
            if (bit_q == BitW'(DR_WIDTH)) begin
              state_q <= StUdr;
              sdr_q   <= 1'b0;
              udr_q   <= 1'b1;
              tdi_q   <= 1'b0;
            end else begin
              tdi_q <= shift_q[0];
            end
          end
        end
        StUdr: begin
          if (fall) begin
            state_q  <= StResp;
            udr_q    <= 1'b0;
            rti_q    <= 1'b1;
            rsp_dr_q <= shift_q;
          end
        end
        StResp: begin
          // One settling clk after the last tck fall before the response is offered.
          if (!rsp_valid_q) begin
            rsp_valid_q <= 1'b1;
          end else if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef VJTAG_SCAN_IR_CAPTURE_EN
  logic [IR_WIDTH-1:0] ir_cap_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      ir_cap_q <= '0;
    end else if ((state_q == StUir) && rise) begin
      ir_cap_q <= ir_out;
    end
  end

  assign rsp_ir_out = ir_cap_q;
`else
  logic unused_ir_out;
  assign unused_ir_out = ^ir_out;
  assign rsp_ir_out    = '0;
`endif

  assign cmd_ready         = cmd_ready_q;
  assign rsp_valid         = rsp_valid_q;
  assign rsp_dr            = rsp_dr_q;
  assign tdi               = tdi_q;
  assign ir_in             = ir_in_q;
  assign jtag_state_rti    = rti_q;
  assign virtual_state_uir = uir_q;
  assign virtual_state_cdr = cdr_q;
  assign virtual_state_sdr = sdr_q;
  assign virtual_state_udr = udr_q;

endmodule

// File: tb/tb_vjtag_scan_master.sv
// Self-checking bench for vjtag_scan_master: cycle model of the scan timeline plus directed checks.
module tb_vjtag_scan_master;

  localparam int IRW = 2;
  localparam int DRW = 38;
  localparam int DIV = 2;
  localparam int P   = 2 * DIV;

`ifdef VJTAG_SCAN_IR_CAPTURE_EN
  localparam bit CapEn = 1'b1;
`else
  localparam bit CapEn = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           cmd_valid = 1'b1;
  logic           cmd_ready;
  logic [IRW-1:0] cmd_ir = '0;
  logic [DRW-1:0] cmd_dr = '0;
  logic           cmd_ir_only = 1'b0;
  logic           rsp_valid;
  logic           rsp_ready = 1'b0;
  logic [DRW-1:0] rsp_dr;
  logic [IRW-1:0] rsp_ir_out;
  logic           tck, tdi, tdo;
  logic [IRW-1:0] ir_in;
  logic [IRW-1:0] ir_out = 2'b01;
  logic           rti, uir, cdr, sdr, udr;
  logic           tdo_loop = 1'b1;
  logic           tdo_const = 1'b0;

  assign tdo = tdo_loop ? tdi : tdo_const;

  always #5 clk = ~clk;

  vjtag_scan_master #(
    .IR_WIDTH(IRW),
    .DR_WIDTH(DRW),
    .TCK_DIV (DIV)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .cmd_valid        (cmd_valid),
    .cmd_ready        (cmd_ready),
    .cmd_ir           (cmd_ir),
    .cmd_dr           (cmd_dr),
    .cmd_ir_only      (cmd_ir_only),
    .rsp_valid        (rsp_valid),
    .rsp_ready        (rsp_ready),
    .rsp_dr           (rsp_dr),
    .rsp_ir_out       (rsp_ir_out),
    .tck              (tck),
    .tdi              (tdi),
    .tdo              (tdo),
    .ir_in            (ir_in),
    .ir_out           (ir_out),
    .jtag_state_rti   (rti),
    .virtual_state_uir(uir),
    .virtual_state_cdr(cdr),
    .virtual_state_sdr(sdr),
    .virtual_state_udr(udr)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a command occupies N tck periods (1 or 3+DRW); the response appears one clk after.
  logic           m_ready = 1'b1;
  logic           m_rv = 1'b0;
  int             m_k = 0;
  int             m_n = 1;
  logic [DRW-1:0] m_dr = '0;
  logic [DRW-1:0] m_rsp = '0;
  logic [IRW-1:0] m_ir_in = '0;
  logic [IRW-1:0] m_rsp_ir = '0;
  logic           armed = 1'b0;

  always @(posedge clk) begin
    armed <= 1'b1;
    if (reset) begin
      m_ready <= 1'b1;
      m_rv    <= 1'b0;
      m_ir_in <= '0;
    end else if (m_ready) begin
      if (cmd_valid) begin
        m_ready  <= 1'b0;
        m_k      <= 0;
        m_n      <= cmd_ir_only ? 1 : 3 + DRW;
        m_dr     <= cmd_dr;
        m_ir_in  <= cmd_ir;
        m_rsp    <= cmd_ir_only ? '0 : (tdo_loop ? cmd_dr : {DRW{tdo_const}});
        m_rsp_ir <= CapEn ? ir_out : '0;
      end
    end else if (m_rv) begin
      if (rsp_ready) begin
        m_rv    <= 1'b0;
        m_ready <= 1'b1;
      end
    end else begin
      m_k <= m_k + 1;
      if (m_k + 1 == m_n * P + 1) m_rv <= 1'b1;
    end
  end

  int         ph;
  logic       e_tck, e_tdi, e_rti, e_uir, e_cdr, e_sdr, e_udr;
  int         c_uir = 0, c_cdr = 0, c_sdr = 0, c_udr = 0;

  always @(negedge clk) begin
    c_uir = c_uir + int'(uir);
    c_cdr = c_cdr + int'(cdr);
    c_sdr = c_sdr + int'(sdr);
    c_udr = c_udr + int'(udr);
    e_tck = 1'b0; e_tdi = 1'b0; e_rti = 1'b1;
    e_uir = 1'b0; e_cdr = 1'b0; e_sdr = 1'b0; e_udr = 1'b0;
    if (!m_ready && m_k < m_n * P) begin
      ph    = m_k / P;
      e_rti = 1'b0;
      e_tck = (m_k % P) >= DIV;
      e_uir = ph == 0;
      e_cdr = ph == 1;
      e_sdr = ph >= 2 && ph < 2 + DRW;
      e_udr = ph == 2 + DRW;
      if (e_sdr) e_tdi = m_dr[ph-2];
    end
    if (armed) begin
      check("outputs{rdy,rv,tck,tdi,rti,uir,cdr,sdr,udr,ir_in}",
            64'({cmd_ready, rsp_valid, tck, tdi, rti, uir, cdr, sdr, udr, ir_in}),
            64'({m_ready, m_rv, e_tck, e_tdi, e_rti, e_uir, e_cdr, e_sdr, e_udr, m_ir_in}));
      if (m_rv) begin
        check("rsp_dr", 64'(rsp_dr), 64'(m_rsp));
        check("rsp_ir_out", 64'(rsp_ir_out), 64'(m_rsp_ir));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [IRW-1:0] ir, input logic [DRW-1:0] dr, input logic only,
                       output int lat);
    cmd_ir      = ir;
    cmd_dr      = dr;
    cmd_ir_only = only;
    cmd_valid   = 1'b1;
    step();
    cmd_valid = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < 2000) begin
      step();
      lat++;
    end
  endtask

  task automatic handshake();
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    step();
  endtask

  int lat;
  int b_uir, b_cdr, b_sdr, b_udr;

  initial begin
    // 1: reset with cmd_valid high
    repeat (3) step();
    check("reset rti", 64'(rti), 64'(1));
    check("reset tck", 64'(tck), 64'(0));
    check("reset cmd_ready", 64'(cmd_ready), 64'(1));
    cmd_valid = 1'b0;
    reset     = 1'b0;
    step();

    // 2: loopback full scan
    b_uir = c_uir; b_cdr = c_cdr; b_sdr = c_sdr; b_udr = c_udr;
    issue(2'b00, 38'h2A_5A5A_5A5A, 1'b0, lat);
    check("full latency", 64'(lat), 64'(165));
    check("loopback rsp_dr", 64'(rsp_dr), 64'(38'h2A_5A5A_5A5A));
    check("full ir_in", 64'(ir_in), 64'(2'b00));
    check("uir clks", 64'(c_uir - b_uir), 64'(4));
    check("cdr clks", 64'(c_cdr - b_cdr), 64'(4));
    check("sdr clks", 64'(c_sdr - b_sdr), 64'(152));
    check("udr clks", 64'(c_udr - b_udr), 64'(4));
    handshake();
    check("ready after rsp", 64'(cmd_ready), 64'(1));

    // 3: IR-only
    b_cdr = c_cdr; b_sdr = c_sdr; b_udr = c_udr;
    issue(2'b11, 38'h15_0F0F_0F0F, 1'b1, lat);
    check("ir-only latency", 64'(lat), 64'(5));
    check("ir-only ir_in", 64'(ir_in), 64'(2'b11));
    check("ir-only no cdr/sdr/udr", 64'((c_cdr - b_cdr) + (c_sdr - b_sdr) + (c_udr - b_udr)),
          64'(0));
    handshake();

    // 4: tdo tied high, response back-pressured, extra command ignored
    tdo_loop  = 1'b0;
    tdo_const = 1'b1;
    issue(2'b01, 38'h0, 1'b0, lat);
    check("ones latency", 64'(lat), 64'(165));
    cmd_valid = 1'b1;
    cmd_ir    = 2'b10;
    repeat (20) step();
    check("ones rsp_dr held", 64'(rsp_dr), 64'({DRW{1'b1}}));
    check("busy cmd_ready", 64'(cmd_ready), 64'(0));
    check("ir_in unchanged", 64'(ir_in), 64'(2'b01));
    cmd_valid = 1'b0;
    handshake();

    // 5: reset during the 10th SDR bit
    tdo_loop  = 1'b1;
    cmd_ir    = 2'b01;
    cmd_dr    = 38'h3F_FFFF_FFFF;
    cmd_ir_only = 1'b0;
    cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    repeat (44) step();
    check("sdr before reset", 64'(sdr), 64'(1));
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("mid-reset outputs{rdy,rv,tck,tdi,rti,uir,cdr,sdr,udr,ir_in}",
          64'({cmd_ready, rsp_valid, tck, tdi, rti, uir, cdr, sdr, udr, ir_in}),
          64'(11'b10001000000));
    check("mid-reset rsp_dr", 64'(rsp_dr), 64'(0));
    check("mid-reset rsp_ir_out", 64'(rsp_ir_out), 64'(0));
    repeat (200) step();
    check("no rsp after reset", 64'(rsp_valid), 64'(0));

    // 6: follow-up command, IR capture
    ir_out = 2'b10;
    issue(2'b10, 38'h01_2345_6789, 1'b0, lat);
    check("post-reset latency", 64'(lat), 64'(165));
    check("post-reset rsp_dr", 64'(rsp_dr), 64'(38'h01_2345_6789));
`ifdef VJTAG_SCAN_IR_CAPTURE_EN
    check("rsp_ir_out captured", 64'(rsp_ir_out), 64'(2'b10));
`else
    check("rsp_ir_out zero", 64'(rsp_ir_out), 64'(2'b00));
`endif
    handshake();
    repeat (4) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
